demux18_deser: RTL and testbench
================================

# demux18_deser

Serial-to-parallel byte collector: the receiving end of the 8:1 bit-select path. A transmitter walks `sel` through 0..7 on an 8:1 mux, and this block writes each arriving bit into the matching position of an 8-bit shadow register. When a byte is complete it is moved into a one-entry output buffer with a valid/ready handshake. It sits between a single-bit serial link and byte-wide consumers.

## Interface
- `LSB_FIRST`, default 1. 1: first bit goes to index 0 and `sel` counts up. 0: first bit goes to index 7 and `sel` counts down.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset; dominates every other input.
- `in`  in  1  serial data bit.
- `in_valid`  in  1  `in` is a valid bit this cycle.
- `sync`  in  1  frame align: discard the partial byte and restart at the first index.
- `out`  out  8  assembled byte (output buffer).
- `out_valid`  out  1  `out` holds an unconsumed byte.
- `out_ready`  in  1  consumer accepts `out` when `out_valid && out_ready`.
- `sel`  out  3  index the next valid bit will be written to.
- `overflow`  out  1  sticky: a completed byte was dropped; cleared only by `rst`.

## Operation
- FIRST = `LSB_FIRST ? 0 : 7`; LAST = `LSB_FIRST ? 7 : 0`. "Step" means +1 if `LSB_FIRST`, else −1; the result is taken mod 8.
- Reset values: `out`=0, `out_valid`=0, `sel`=FIRST, `overflow`=0, shadow=0.
- `in_valid` && !`sync` && `sel`≠LAST: `shadow[sel]` <= `in`, `sel` <= step(`sel`).
- `in_valid` && !`sync` && `sel`==LAST (completion):
  - byte = shadow with bit `sel` replaced by `in`; `sel` <= FIRST; shadow <= 0.
  - If !`out_valid` or `out_ready`: `out` <= byte, `out_valid` <= 1.
  - Otherwise the byte is dropped, `out` and `out_valid` are unchanged, and `overflow` <= 1.
- `sync` && `in_valid`: shadow <= 0 except shadow[FIRST] <= `in`; `sel` <= step(FIRST). No completion occurs, even if `sel` was LAST.
- `sync` && !`in_valid`: shadow <= 0, `sel` <= FIRST.
- No completion this cycle and `out_valid && out_ready`: `out_valid` <= 0; `out` holds its value.
- A completion in the same cycle as a consumer pop: the new byte loads and `out_valid` stays 1, i.e. back-to-back throughput with no bubble.
- `in_valid`=0 with `sync`=0: shadow and `sel` hold; gaps between bits are unlimited.
- Internally the block is a 2-state buffer FSM, EMPTY (`out_valid`=0) and FULL (`out_valid`=1):
  - EMPTY → FULL on completion.
  - FULL → EMPTY on a pop without completion.
  - FULL → FULL on completion with a pop, or on completion without a pop (overflow).
- Bit ordering: a transmitter that drives a mux with `sel` = 0,1,..,7 (mux output = `byte[sel]`) into this block with `LSB_FIRST`=1 reconstructs the byte exactly.

## Timing
- Latency: a byte is presented on `out` with `out_valid`=1 in the cycle after the edge that samples its last bit, i.e. 1 cycle.
- `sel`, `out`, `out_valid` and `overflow` are registered outputs with no combinational path from inputs.
- `out_ready` is sampled only while `out_valid`=1; it is ignored otherwise.
- Reset mid-byte or mid-handshake: on the next edge all state returns to reset values. The partial byte and any buffered byte are lost without setting `overflow`.
- `rst` together with `sync`/`in_valid`: reset wins and the bit is ignored.
- Sustained rate: 1 bit/cycle in, 1 byte per 8 cycles out. The buffer never overflows if the consumer holds `out_ready`=1.

## Test plan
- Reset, then with `LSB_FIRST`=1 feed bits 1,0,1,1,0,0,1,0 (index 0 first) on consecutive cycles with `out_ready`=1:
  - `sel` steps 0→7→0.
  - 1 cycle after the 8th bit, `out`=8'h4D and `out_valid`=1 for one cycle.
- `LSB_FIRST`=0, feed 8'hA5 MSB first:
  - `sel` steps 7→0.
  - `out`=8'hA5.
- `out_ready`=0, send 8'h11 then 8'h22:
  - `out`=8'h11 and `out_valid` held.
  - 1 cycle after the 16th bit, `overflow`=1 and `out` is still 8'h11.
  - Raise `out_ready`: `out_valid` falls and `overflow` stays 1.
- Continuous stream 8'h01, 8'h02, 8'h03 with `out_ready` pulsed exactly in each completion cycle:
  - `out_valid` never drops between bytes.
  - `overflow` stays 0.
- Send 5 bits, then `sync` with `in_valid`, `in`=1, then 7 more bits all 0:
  - `out`=8'h01; the partial byte is discarded.
  - `sync` alone with `in_valid`=0 sets `sel`=0.
- Assert `rst` after 4 bits while `out_valid`=1:
  - Next cycle: `out`=0, `out_valid`=0, `sel`=0, `overflow`=0.
  - A following full byte 8'hFF is collected correctly.

Source files
------------

// File: rtl/demux18_deser.sv
// Serial-to-parallel byte collector: writes each valid bit into shadow[sel] and
// moves each completed byte into a one-entry valid/ready output buffer.
module demux18_deser #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       in_valid,
  input  logic       sync,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic       overflow
);

  localparam logic [2:0] FIRST = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [2:0] LAST  = (LSB_FIRST != 0) ? 3'd7 : 3'd0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] out_q, out_d;
  logic       ovf_q, ovf_d;
  logic       complete_s;
  logic [7:0] byte_s;

  function automatic logic [2:0] step(input logic [2:0] s);
    if (LSB_FIRST != 0) begin
      return s + 3'd1;
    end else begin
      return s - 3'd1;
    end
  endfunction

  // Bit collection: sync overrides everything except reset and never completes a byte.
  always_comb begin
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    complete_s = 1'b0;
    byte_s     = shadow_q;
    if (sync) begin
      shadow_d = 8'd0;
      if (in_valid) begin
        shadow_d[FIRST] = in;
        sel_d           = step(FIRST);
      end else begin
        sel_d = FIRST;
      end
    end else if (in_valid) begin
      if (sel_q == LAST) begin
        complete_s    = 1'b1;
        byte_s[sel_q] = in;
        shadow_d      = 8'd0;
        sel_d         = FIRST;
      end else begin
        shadow_d[sel_q] = in;
        sel_d           = step(sel_q);
      end
    end else begin
      sel_d    = sel_q;
      shadow_d = shadow_q;
    end
  end

  // Output buffer FSM; a completion during a pop reloads with no bubble.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    case (state_q)
      EMPTY: begin
        if (complete_s) begin
          state_d = FULL;
          out_d   = byte_s;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (complete_s) begin
          state_d = FULL;
          if (out_ready) begin
            out_d = byte_s;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (out_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      sel_q    <= FIRST;
      shadow_q <= 8'd0;
      out_q    <= 8'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == FULL);
  assign sel       = sel_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_demux18_deser.sv
// Directed bench for demux18_deser: an LSB-first and an MSB-first instance share
// one stimulus stream; each scenario checks the instance it targets.
module tb_demux18_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_b = 1'b0;
  logic       in_valid = 1'b0;
  logic       sync = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] l_out, m_out;
  logic       l_valid, m_valid;
  logic [2:0] l_sel, m_sel;
  logic       l_ovf, m_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux18_deser #(.LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .sync(sync),
    .out(l_out), .out_valid(l_valid), .out_ready(out_ready), .sel(l_sel), .overflow(l_ovf)
  );

  demux18_deser #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .sync(sync),
    .out(m_out), .out_valid(m_valid), .out_ready(out_ready), .sel(m_sel), .overflow(m_ovf)
  );

  typedef struct {
    logic       in_b;
    logic       vld;
    logic       syn;
    logic       rdy;
    logic [2:0] e_sel;
    logic [7:0] e_out;
    logic       e_valid;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_b     = 1'b0;
  endtask

  task automatic send_lsb(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; sync = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] stream [3];

    // Bits 1,0,1,1,0,0,1,0 at index 0..7 assemble 8'h4D.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h4D, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h4D, 1'b0, 1'b0};

    // Reset values.
    do_reset();
    check("rst_out", l_out, 8'h00);
    check("rst_valid", {7'd0, l_valid}, 8'h00);
    check("rst_sel_lsb", {5'd0, l_sel}, 8'h00);
    check("rst_sel_msb", {5'd0, m_sel}, 8'h07);
    check("rst_ovf", {7'd0, l_ovf}, 8'h00);

    // Table-driven LSB-first byte.
    for (int i = 0; i < 9; i++) begin
      in_b = vecs[i].in_b; in_valid = vecs[i].vld; sync = vecs[i].syn; out_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_sel", i), {5'd0, l_sel}, {5'd0, vecs[i].e_sel});
      check($sformatf("vec%0d_out", i), l_out, vecs[i].e_out);
      check($sformatf("vec%0d_valid", i), {7'd0, l_valid}, {7'd0, vecs[i].e_valid});
      check($sformatf("vec%0d_ovf", i), {7'd0, l_ovf}, {7'd0, vecs[i].e_ovf});
    end
    in_valid = 1'b0;

    // MSB-first: 8'hA5 sent bit 7 first, sel counts down 7..0.
    do_reset();
    out_ready = 1'b1;
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      send_bit(a5[i]);
      check("msb_sel", {5'd0, m_sel}, (i == 0) ? 8'd7 : 8'(i - 1));
    end
    check("msb_out", m_out, 8'hA5);
    check("msb_valid", {7'd0, m_valid}, 8'h01);

    // Overflow: consumer stalled across two bytes.
    do_reset();
    send_lsb(8'h11);
    check("ovf_first_out", l_out, 8'h11);
    check("ovf_first_valid", {7'd0, l_valid}, 8'h01);
    check("ovf_first_flag", {7'd0, l_ovf}, 8'h00);
    send_lsb(8'h22);
    check("ovf_flag", {7'd0, l_ovf}, 8'h01);
    check("ovf_out_kept", l_out, 8'h11);
    check("ovf_valid_kept", {7'd0, l_valid}, 8'h01);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ovf_pop_valid", {7'd0, l_valid}, 8'h00);
    check("ovf_sticky", {7'd0, l_ovf}, 8'h01);

    // Back-to-back stream with out_ready only in each completion cycle.
    do_reset();
    stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        out_ready = (i == 7) ? 1'b1 : 1'b0;
        send_bit(stream[k][i]);
        if (k > 0 || i == 7) check("b2b_valid", {7'd0, l_valid}, 8'h01);
      end
      check("b2b_out", l_out, stream[k]);
      check("b2b_ovf", {7'd0, l_ovf}, 8'h00);
    end
    out_ready = 1'b0;

    // Sync with a bit restarts framing; partial byte is discarded.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    sync = 1'b1;
    send_bit(1'b1);
    sync = 1'b0;
    check("sync_bit_sel", {5'd0, l_sel}, 8'h01);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check("sync_out", l_out, 8'h01);
    check("sync_valid", {7'd0, l_valid}, 8'h01);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_only_sel", {5'd0, l_sel}, 8'h00);
    send_lsb(8'h80);
    check("sync_clears_shadow", l_out, 8'h80);

    // Reset mid-byte with a buffered byte, reset wins over a concurrent bit.
    do_reset();
    send_lsb(8'h5A);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("pre_rst_valid", {7'd0, l_valid}, 8'h01);
    rst = 1'b1; in_valid = 1'b1; in_b = 1'b1; sync = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_b = 1'b0; sync = 1'b0;
    check("mid_rst_out", l_out, 8'h00);
    check("mid_rst_valid", {7'd0, l_valid}, 8'h00);
    check("mid_rst_sel", {5'd0, l_sel}, 8'h00);
    check("mid_rst_ovf", {7'd0, l_ovf}, 8'h00);
    send_lsb(8'hFF);
    check("post_rst_out", l_out, 8'hFF);
    check("post_rst_valid", {7'd0, l_valid}, 8'h01);
    check("post_rst_ovf", {7'd0, l_ovf}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
